// File: rtl/rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_instr_encoder
//  Purpose  : Turns structured operation descriptors (class, funct3, funct7
//             bit 5, rd/rs1/rs2, byte-offset immediate) into 32-bit RV32I
//             instruction words. Streams them with sequential word addresses.
//             Each start pulse runs one burst of a programmed length.
//             Illegal descriptors are consumed and replaced by a NOP flagged
//             with out_illegal, and they bump a saturating error counter.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             start, base_addr, len - burst control (sampled in IDLE)
//             in_valid / in_ready   - descriptor handshake
//             op_class, fun3, fun7, rd, rs1, rs2, imm - descriptor fields
//             out_valid / out_ready - instruction word handshake
//             out_instr, out_addr, out_illegal - registered output word
//             busy, done, err_count - status
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_class,
    input  logic [2:0]        fun3,
    input  logic              fun7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_illegal,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [6:0] c_opc_r      = 7'b0110011;
    localparam logic [6:0] c_opc_i      = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [31:0]       c_nop       = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);
    localparam logic [LEN_W-1:0]  c_len_one   = LEN_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_illegal;
    logic [7:0]        r_err_count;

    logic              w_accept;
    logic              w_out_fire;
    logic              w_illegal;
    logic [31:0]       w_word;
    logic [31:0]       w_instr;

    // Single output register: a new descriptor may enter whenever the slot is
    // empty or is being emptied this very cycle.
    assign in_ready   = (r_state == c_st_run) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Descriptor encoder
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal = 1'b0;
        w_word    = 32'h0;
        case (op_class)
            4'd0: begin
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                w_word    = {1'b0, fun7, 5'b0, rs2, rs1, fun3, rd, c_opc_r};
                w_illegal = fun7 && (fun3 != 3'b000) && (fun3 != 3'b101);
            end
            4'd1: begin
                if ((fun3 == 3'b001) || (fun3 == 3'b101)) begin
                    // Shift-immediate: shamt in [24:20], SRAI flag in bit 30.
                    w_word = {1'b0, fun7, 5'b0, imm[4:0], rs1, fun3, rd, c_opc_i};
                end else begin
                    w_word = {imm[11:0], rs1, fun3, rd, c_opc_i};
                end
                w_illegal = (fun3 == 3'b001) && fun7;
            end
            4'd2: begin
                w_word    = {imm[11:0], rs1, fun3, rd, c_opc_load};
                w_illegal = (fun3 == 3'b011) || (fun3 == 3'b110) || (fun3 == 3'b111);
            end
            4'd3: begin
                w_word    = {imm[11:5], rs2, rs1, fun3, imm[4:0], c_opc_store};
                w_illegal = (fun3 > 3'b010);
            end
            4'd4: begin
                w_word    = {imm[12], imm[10:5], rs2, rs1, fun3, imm[4:1], imm[11], c_opc_branch};
                w_illegal = (fun3 == 3'b010) || (fun3 == 3'b011) || imm[0];
            end
            4'd5: begin
                w_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, c_opc_jal};
                w_illegal = imm[0];
            end
            4'd6: begin
                w_word    = {imm[11:0], rs1, 3'b000, rd, c_opc_jalr};
                w_illegal = (fun3 != 3'b000);
            end
            4'd7: begin
                w_word = {imm[31:12], rd, c_opc_lui};
            end
            4'd8: begin
                w_word = {imm[31:12], rd, c_opc_auipc};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        w_instr = w_illegal ? c_nop : w_word;
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = (len == '0) ? c_st_done : c_st_run;
                end
            end
            c_st_run: begin
                if (w_accept && (r_remaining == c_len_one)) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                // Wait for the last word to leave the output register.
                if (w_out_fire) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_out_valid   <= 1'b0;
            r_out_instr   <= 32'h0;
            r_out_addr    <= '0;
            r_out_illegal <= 1'b0;
            r_err_count   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == c_st_idle) && start) begin
                r_cur_addr  <= base_addr;
                r_remaining <= len;
            end else if (w_accept) begin
                r_cur_addr  <= r_cur_addr + c_addr_step;
                r_remaining <= r_remaining - c_len_one;
            end

            // Accept wins over drain so a simultaneous handshake and accept
            // reloads the register without a bubble.
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_instr   <= w_instr;
                r_out_addr    <= r_cur_addr;
                r_out_illegal <= w_illegal;
                if (w_illegal && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else if (w_out_fire) begin
                r_out_valid   <= 1'b0;
                r_out_illegal <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_addr    = r_out_addr;
    assign out_illegal = r_out_illegal;
    assign err_count   = r_err_count;
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);

endmodule
`default_nettype wire
